// File: rtl/pc_pkg.sv
// Shared types and default parameters for the fetch-stage PC/NPC unit.
package pc_pkg;

  // RUN: the instruction at PC is not a delay slot; SLOT: it is.
  typedef enum logic {
    RUN  = 1'b0,
    SLOT = 1'b1
  } pc_state_t;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_INC        = 4;
  localparam int unsigned DEF_TRAP_VEC   = 'h80;
  localparam int unsigned DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational address incrementer: sum_c = a + INC, modulo 2^WIDTH.
module pc_incrementer import pc_pkg::*; #(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned INC   = DEF_INC
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum_c
);

  // Wraps silently at the top of the address space.
  assign sum_c = a + WIDTH'(INC);

endmodule

// File: rtl/pc_npc_unit.sv
// Fetch-stage PC/NPC pair with delayed branches, annulled slots, jumps and traps.
module pc_npc_unit import pc_pkg::*; #(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned      INC        = DEF_INC,
  parameter int unsigned      TRAP_VEC   = DEF_TRAP_VEC,
  parameter int unsigned      ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             le,
  input  logic             br_taken,
  input  logic             br_annul,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             trap,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] npc_out,
  output logic             annul_out,
  output logic             in_slot,
  output logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] enpc,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] TRAP_PC  = WIDTH'(TRAP_VEC);
  localparam logic [WIDTH-1:0] TRAP_NPC = WIDTH'(TRAP_VEC + INC);
  localparam logic [WIDTH-1:0] RST_NPC  = RESET_PC + WIDTH'(INC);

  pc_state_t        state, state_d;
  logic [WIDTH-1:0] pc_d, npc_d, epc_d, enpc_d;
  logic             annul_d;
  logic [WIDTH-1:0] npc_inc_c, jmp_inc_c;
  logic             bad_c;

  pc_incrementer #(.WIDTH(WIDTH), .INC(INC)) u_npc_inc (
    .a     (npc_out),
    .sum_c (npc_inc_c)
  );

  pc_incrementer #(.WIDTH(WIDTH), .INC(INC)) u_jmp_inc (
    .a     (jmp_target),
    .sum_c (jmp_inc_c)
  );

  // A misaligned redirect target becomes a trap; only meaningful when advancing.
  assign bad_c = le & ((br_taken & (|br_target[ALIGN_BITS-1:0]))
                     | (jmp & (|jmp_target[ALIGN_BITS-1:0])));

  assign in_slot = (state == SLOT);

  // Priority mux: trap > stall > jump > taken branch > annul-only > sequential.
  always_comb begin
    pc_d    = pc_out;
    npc_d   = npc_out;
    annul_d = annul_out;
    state_d = state;
    epc_d   = epc;
    enpc_d  = enpc;
    if (trap | bad_c) begin
      epc_d   = pc_out;
      enpc_d  = npc_out;
      pc_d    = TRAP_PC;
      npc_d   = TRAP_NPC;
      annul_d = 1'b0;
      state_d = RUN;
    end else if (!le) begin
      // stall: everything holds
    end else if (jmp) begin
      pc_d    = jmp_target;
      npc_d   = jmp_inc_c;
      annul_d = 1'b0;
      state_d = RUN;
    end else if (br_taken & !annul_out) begin
      pc_d    = npc_out;
      npc_d   = br_target;
      annul_d = br_annul;
      state_d = SLOT;
    end else if (br_annul & !annul_out) begin
      pc_d    = npc_out;
      npc_d   = npc_inc_c;
      annul_d = 1'b1;
      state_d = SLOT;
    end else begin
      pc_d    = npc_out;
      npc_d   = npc_inc_c;
      annul_d = 1'b0;
      state_d = RUN;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out    <= RESET_PC;
      npc_out   <= RST_NPC;
      annul_out <= 1'b0;
      state     <= RUN;
      epc       <= '0;
      enpc      <= '0;
      misalign  <= 1'b0;
    end else begin
      pc_out    <= pc_d;
      npc_out   <= npc_d;
      annul_out <= annul_d;
      state     <= state_d;
      epc       <= epc_d;
      enpc      <= enpc_d;
      misalign  <= bad_c;
    end
  end

endmodule
